// File: rtl/seg7_pkg.sv
// Shared opcodes, glyph constants and hex glyph decoder
// for the multi-digit 7-segment custom instruction.
package seg7_pkg;

  localparam logic [2:0] OP_WR_HEX = 3'd0;
  localparam logic [2:0] OP_WR_RAW = 3'd1;
  localparam logic [2:0] OP_WR_DEC = 3'd2;
  localparam logic [2:0] OP_BLANK  = 3'd3;
  localparam logic [2:0] OP_READ   = 3'd4;
  localparam logic [2:0] OP_CLEAR  = 3'd5;

  localparam logic [6:0]  SEG_OFF    = 7'h00;
  localparam logic [6:0]  SEG_DASH   = 7'h40;
  localparam logic [31:0] ERR_RESULT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_WRITE,
    S_DONE
  } ci_state_t;

  // Active-high gfedcba glyphs, A-F drawn as A b C d E F
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// Sequential double-dabble converter, one shift per enabled cycle.
// Overflow is sticky when a carry leaves the top BCD digit.
module seg7_bin2bcd #(
  parameter int DEC_W      = 20,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    start,
  input  logic [DEC_W-1:0]        value,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    overflow
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = (DEC_W > 1) ? $clog2(DEC_W) : 1;

  logic [DEC_W-1:0] bin_q;
  logic [BW-1:0]    bcd_q;
  logic [BW-1:0]    adj;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             ovf_q;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i+:4] >= 4'd5)
        adj[4*i+:4] = bcd_q[4*i+:4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (en) begin
      if (start) begin
        bin_q  <= value;
        bcd_q  <= '0;
        cnt_q  <= CW'(DEC_W - 1);
        busy_q <= 1'b1;
        ovf_q  <= 1'b0;
      end else if (busy_q) begin
        bcd_q  <= {adj[BW-2:0], bin_q[DEC_W-1]};
        bin_q  <= bin_q << 1;
        ovf_q  <= ovf_q | adj[BW-1];
        busy_q <= (cnt_q != '0);
        cnt_q  <= cnt_q - 1'b1;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q & en & (cnt_q == '0);
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/ci_seg7_multidigit.sv
// Multi-cycle custom instruction driving a bank of
// 7-segment digits with hex, raw and decimal writes.
module ci_seg7_multidigit
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DEC_W      = 20,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    start,
  input  logic [2:0]              n,
  input  logic [31:0]             dataa,
  input  logic [31:0]             datab,
  output logic [31:0]             result,
  output logic                    done,
  output logic [7*NUM_DIGITS-1:0] seg_out
);

  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW   = 7 * NUM_DIGITS;

  ci_state_t state_q, state_d;

  logic [NUM_DIGITS-1:0][6:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0]      mask_q, mask_d;
  logic [31:0]                res_q, res_d;
  logic [SW-1:0]              seg_q, seg_d;
  logic                       lzb_q, lzb_d;

  logic [IDXW-1:0]         idx;
  logic                    idx_ok;
  logic                    lz;
  logic [3:0]              nib;
  logic [6:0]              s;
  logic                    conv_start;
  logic                    conv_busy;
  logic                    conv_done;
  logic                    conv_ovf;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic                    unused_bits;

  assign unused_bits = ^{dataa, datab};

  seg7_bin2bcd #(
    .DEC_W      (DEC_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bcd (
    .clk      (clk),
    .reset    (reset),
    .en       (clk_en),
    .start    (conv_start),
    .value    (dataa[DEC_W-1:0]),
    .busy     (conv_busy),
    .done     (conv_done),
    .bcd      (bcd),
    .overflow (conv_ovf)
  );

  assign idx    = datab[IDXW-1:0];
  assign idx_ok = 32'(idx) < 32'(NUM_DIGITS);

  always_comb begin
    state_d    = state_q;
    dig_d      = dig_q;
    mask_d     = mask_q;
    res_d      = res_q;
    lzb_d      = lzb_q;
    conv_start = 1'b0;
    lz         = 1'b0;
    nib        = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          res_d   = '0;
          state_d = S_DONE;
          unique case (1'b1)
            n == OP_WR_HEX: begin
              if (idx_ok) dig_d[idx] = hex_to_seg(dataa[3:0]);
              else        res_d      = ERR_RESULT;
            end
            n == OP_WR_RAW: begin
              if (idx_ok) dig_d[idx] = dataa[6:0];
              else        res_d      = ERR_RESULT;
            end
            n == OP_WR_DEC: begin
              conv_start = 1'b1;
              lzb_d      = datab[0];
              state_d    = S_LOAD;
            end
            n == OP_BLANK: mask_d = dataa[NUM_DIGITS-1:0];
            n == OP_READ: begin
              if (idx_ok) res_d = {25'b0, dig_q[idx]};
              else        res_d = ERR_RESULT;
            end
            n == OP_CLEAR: begin
              dig_d  = '0;
              mask_d = '0;
            end
            default: res_d = ERR_RESULT;
          endcase
        end
      end
      S_LOAD:  state_d = conv_done ? S_WRITE : S_SHIFT;
      S_SHIFT: if (conv_done || !conv_busy) state_d = S_WRITE;
      S_WRITE: begin
        state_d = S_DONE;
        lz      = lzb_q;
        // Units digit is never blanked so zero still shows
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
          nib = bcd[4*k+:4];
          if (lz && nib == 4'd0 && k != 0) begin
            dig_d[k] = SEG_OFF;
          end else begin
            lz       = 1'b0;
            dig_d[k] = hex_to_seg(nib);
          end
        end
        if (conv_ovf) begin
          dig_d = {NUM_DIGITS{SEG_DASH}};
          res_d = 32'd1;
        end else begin
          res_d = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output register tracks the next digit state so the
  // display is current by the time done rises
  always_comb begin
    seg_d = '0;
    s     = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      s = mask_d[k] ? SEG_OFF : dig_d[k];
      seg_d[7*k+:7] = ACTIVE_LOW ? ~s : s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      dig_q   <= '0;
      mask_q  <= '0;
      res_q   <= '0;
      lzb_q   <= 1'b0;
      seg_q   <= {SW{ACTIVE_LOW}};
    end else if (clk_en) begin
      state_q <= state_d;
      dig_q   <= dig_d;
      mask_q  <= mask_d;
      res_q   <= res_d;
      lzb_q   <= lzb_d;
      seg_q   <= seg_d;
    end
  end

  assign done    = clk_en & (state_q == S_DONE);
  assign result  = res_q;
  assign seg_out = seg_q;

endmodule

// File: tb/tb_ci_seg7_multidigit.sv
// Scoreboard bench: stimulus queues expected result/display/
// completion cycle, a negedge monitor checks each done pulse.
module tb_ci_seg7_multidigit;
  import seg7_pkg::*;

  localparam int ND = 6;
  localparam int SW = 7 * ND;

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          clk_en = 1'b1;
  logic          start  = 1'b0;
  logic [2:0]    n      = '0;
  logic [31:0]   dataa  = '0;
  logic [31:0]   datab  = '0;
  logic [31:0]   result;
  logic          done;
  logic [SW-1:0] seg_out;

  ci_seg7_multidigit dut (
    .clk     (clk),
    .reset   (reset),
    .clk_en  (clk_en),
    .start   (start),
    .n       (n),
    .dataa   (dataa),
    .datab   (datab),
    .result  (result),
    .done    (done),
    .seg_out (seg_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]   res;
    logic [SW-1:0] seg;
    int            due;
    int            id;
  } exp_t;

  exp_t       sb[$];
  logic [6:0] mdig[ND];
  logic [ND-1:0] mmask;
  int checks   = 0;
  int failures = 0;
  int op_id    = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] model_seg();
    logic [SW-1:0] r;
    r = '0;
    for (int k = 0; k < ND; k++)
      r[7*k+:7] = ~(mmask[k] ? 7'h00 : mdig[k]);
    return r;
  endfunction

  task automatic set_digits(input logic [6:0] d5, d4, d3, d2, d1, d0);
    mdig[5] = d5; mdig[4] = d4; mdig[3] = d3;
    mdig[2] = d2; mdig[1] = d1; mdig[0] = d0;
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("op%0d_result", e.id), 64'(result), 64'(e.res));
        chk($sformatf("op%0d_seg", e.id), 64'(seg_out), 64'(e.seg));
        chk($sformatf("op%0d_latency", e.id), 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int lat,
                       input logic [31:0] res, input bit track);
    exp_t e;
    @(negedge clk);
    start = 1'b1; n = op; dataa = a; datab = b;
    if (track) begin
      e.res = res; e.seg = model_seg(); e.due = cyc + lat; e.id = op_id;
      sb.push_back(e);
    end
    op_id++;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int lat,
                     input logic [31:0] res);
    issue(op, a, b, lat, res, 1'b1);
    wait_drain(lat + 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < ND; k++) mdig[k] = 7'h00;
    mmask = '0;
    repeat (3) @(negedge clk);
    chk("reset_seg", 64'(seg_out), 64'({SW{1'b1}}));
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    reset = 1'b0;

    mdig[2] = 7'h77;
    run(OP_WR_HEX, 32'hA, 32'd2, 1, 32'd0);
    chk("hex_a_digit2", 64'(seg_out[20:14]), 64'h08);

    set_digits(7'h00, 7'h00, 7'h06, 7'h5B, 7'h4F, 7'h66);
    run(OP_WR_DEC, 32'd1234, 32'd1, 22, 32'd0);
    set_digits(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
    run(OP_WR_DEC, 32'd1000000, 32'd0, 22, 32'd1);
    set_digits(7'h6F, 7'h6F, 7'h6F, 7'h6F, 7'h6F, 7'h6F);
    run(OP_WR_DEC, 32'd999999, 32'd1, 22, 32'd0);
    set_digits(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F);
    run(OP_WR_DEC, 32'd0, 32'd1, 22, 32'd0);
    set_digits(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h07);
    run(OP_WR_DEC, 32'd7, 32'd0, 22, 32'd0);

    mdig[0] = 7'h55;
    run(OP_WR_RAW, 32'hFFFF_FF55, 32'd0, 1, 32'd0);
    mmask = 6'b000101;
    run(OP_BLANK, 32'd5, 32'd0, 1, 32'd0);
    run(OP_READ, 32'd0, 32'd0, 1, 32'h55);
    run(OP_READ, 32'd0, 32'd2, 1, 32'h3F);
    run(OP_READ, 32'd0, 32'd7, 1, ERR_RESULT);
    run(3'd6, 32'h1234, 32'd0, 1, ERR_RESULT);
    run(3'd7, 32'h0, 32'd1, 1, ERR_RESULT);
    run(OP_WR_HEX, 32'd1, 32'd6, 1, ERR_RESULT);
    run(OP_WR_RAW, 32'h7F, 32'd7, 1, ERR_RESULT);
    run(OP_READ, 32'd0, 32'd5, 1, 32'h3F);

    set_digits(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
    mmask = '0;
    run(OP_CLEAR, 32'd0, 32'd0, 1, 32'd0);
    mdig[1] = 7'h71;
    run(OP_WR_HEX, 32'hF, 32'd1, 1, 32'd0);

    set_digits(7'h00, 7'h00, 7'h00, 7'h00, 7'h66, 7'h5B);
    issue(OP_WR_DEC, 32'd42, 32'd1, 25, 32'd0, 1'b1);
    repeat (3) @(negedge clk);
    clk_en = 1'b0;
    repeat (3) @(negedge clk);
    clk_en = 1'b1;
    @(negedge clk);
    start = 1'b1; n = OP_WR_HEX; dataa = 32'd8; datab = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_drain(40);

    issue(OP_WR_DEC, 32'd1234, 32'd0, 22, 32'd0, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_digits(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
    mmask = '0;
    repeat (30) @(negedge clk);
    chk("abort_seg", 64'(seg_out), 64'({SW{1'b1}}));
    chk("abort_result", 64'(result), 64'd0);

    run(OP_READ, 32'd0, 32'd1, 1, 32'd0);
    mdig[0] = 7'h4F;
    run(OP_WR_HEX, 32'd3, 32'd0, 1, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
